// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit synchroniser, stability-counter debounce,
// rise/fall pulses and a zero-extended read word. SW_STICKY_EVENT_EN adds sticky change flags.
module switch_debouncer #(
    parameter int NUM_SW          = 8,
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_clean,
    output logic [WIDTH-1:0]  sw_word,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    input  logic              clr_event,
    output logic [NUM_SW-1:0] sw_event
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0]                r_sync [SYNC_STAGES];
    logic [NUM_SW-1:0]                w_synced;
    logic [NUM_SW-1:0][CNT_WIDTH-1:0] r_cnt;
    logic [NUM_SW-1:0][CNT_WIDTH-1:0] w_cnt_nxt;
    logic [NUM_SW-1:0]                r_clean;
    logic [NUM_SW-1:0]                w_clean_nxt;
    logic [NUM_SW-1:0]                r_rise;
    logic [NUM_SW-1:0]                w_rise_nxt;
    logic [NUM_SW-1:0]                r_fall;
    logic [NUM_SW-1:0]                w_fall_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a signal unassigned and infer a latch.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_clean;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (w_synced[i] == r_clean[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_LAST) begin
                w_cnt_nxt[i]   = '0;
                w_clean_nxt[i] = w_synced[i];
                w_rise_nxt[i]  = w_synced[i];
                w_fall_nxt[i]  = ~w_synced[i];
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    // Counters are reset too, so a count pending at reset is discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_clean <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign sw_clean = r_clean;
    assign sw_word  = WIDTH'(r_clean);
    assign sw_rise  = r_rise;
    assign sw_fall  = r_fall;

`ifdef SW_STICKY_EVENT_EN
    logic [NUM_SW-1:0] r_event;

    // A new pulse is ORed in after the clear, so set beats clear on the same bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_event <= '0;
        end else begin
            r_event <= (clr_event ? '0 : r_event) | r_rise | r_fall;
        end
    end

    assign sw_event = r_event;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_event;
    assign sw_event     = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed test-plan scenarios plus random
// toggling, compared every cycle against a sliding-window reference model.
module tb_switch_debouncer;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int CW = 3;
`ifdef SW_STICKY_EVENT_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sw_raw = '0;
    logic         clr_event = 1'b0;
    logic [N-1:0] sw_clean, sw_rise, sw_fall, sw_event;
    logic [W-1:0] sw_word;

    int n_checks = 0;
    int n_fail   = 0;

    switch_debouncer #(
        .NUM_SW(N), .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_clean(sw_clean),
        .sw_word(sw_word), .sw_rise(sw_rise), .sw_fall(sw_fall),
        .clr_event(clr_event), .sw_event(sw_event)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a bit flips once the last D synced samples since reset
    // all disagree with its clean value; synced is the raw sample S edges back.
    logic [N-1:0] raw_q [$];
    logic [N-1:0] syn_q [$];
    logic [N-1:0] m_clean = '0;
    logic [N-1:0] m_rise  = '0;
    logic [N-1:0] m_fall  = '0;
    logic [N-1:0] m_event = '0;

    function automatic logic [N-1:0] accept(input logic [N-1:0] clean);
        logic [N-1:0] res = clean;
        if (syn_q.size() < D) return clean;
        for (int i = 0; i < N; i++) begin
            logic all_diff = 1'b1;
            for (int j = 0; j < syn_q.size(); j++)
                if (syn_q[j][i] == clean[i]) all_diff = 1'b0;
            if (all_diff) res[i] = ~clean[i];
        end
        return res;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_q.delete();
            syn_q.delete();
            m_clean <= '0;
            m_rise  <= '0;
            m_fall  <= '0;
            m_event <= '0;
        end else begin
            syn_q.push_back((raw_q.size() >= S) ? raw_q[raw_q.size()-S] : {N{1'b0}});
            if (syn_q.size() > D) void'(syn_q.pop_front());
            raw_q.push_back(sw_raw);
            if (raw_q.size() > S) void'(raw_q.pop_front());
            m_clean <= accept(m_clean);
            m_rise  <= accept(m_clean) & ~m_clean;
            m_fall  <= ~accept(m_clean) & m_clean;
            if (STICKY) m_event <= (clr_event ? '0 : m_event) | m_rise | m_fall;
        end
    end

    always @(negedge clk) begin
        check("clean", 32'(sw_clean), 32'(m_clean));
        check("word",  32'(sw_word),  32'(m_clean));
        check("rise",  32'(sw_rise),  32'(m_rise));
        check("fall",  32'(sw_fall),  32'(m_fall));
        check("event", 32'(sw_event), 32'(m_event));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    logic [N-1:0] seen;
    logic [N-1:0] flip;
    int           rst_left;

    initial begin
        // Reset release with all switches high
        #1 reset = 1'b0;
        sw_raw = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_clean", 32'(sw_clean), 32'h0);
            check("rst_word",  32'(sw_word),  32'h0);
            check("rst_rise",  32'(sw_rise),  32'h0);
        end
        #1 reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) check("pwr_clean_e5", 32'(sw_clean), 32'h0);
            if (k == 6) begin
                check("pwr_clean_e6", 32'(sw_clean), 32'hFF);
                check("pwr_rise_e6",  32'(sw_rise),  32'hFF);
                check("pwr_word_e6",  32'(sw_word),  32'h00FF);
            end
            if (k == 7) check("pwr_rise_e7", 32'(sw_rise), 32'h0);
        end

        // Bounce on bit0 never gets accepted
        idle(1);
        sw_raw = 8'h00;
        idle(10);
        seen = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            seen |= sw_rise | sw_fall;
            #1 sw_raw[0] = c[1];
        end
        sw_raw = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen |= sw_rise | sw_fall;
        end
        check("bounce_pulses", 32'(seen), 32'h0);
        check("bounce_clean",  32'(sw_clean), 32'h0);

        // Stable fall on bit3
        idle(1);
        sw_raw = 8'hFF;
        idle(10);
        sw_raw = 8'hF7;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) check("fall_clean_e5", 32'(sw_clean), 32'hFF);
            if (k == 6) begin
                check("fall_pulse_e6", 32'(sw_fall),  32'h08);
                check("fall_clean_e6", 32'(sw_clean), 32'hF7);
                check("fall_word_e6",  32'(sw_word),  32'h00F7);
            end
            if (k == 7) check("fall_pulse_e7", 32'(sw_fall), 32'h0);
        end

        // Reset in the middle of a count
        idle(1);
        sw_raw = 8'h00;
        idle(10);
        sw_raw = 8'h80;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_clean", 32'(sw_clean), 32'h0);
            check("midrst_word",  32'(sw_word),  32'h0);
        end
        #1 reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) check("midrst_clean_e5", 32'(sw_clean), 32'h00);
            if (k == 6) begin
                check("midrst_clean_e6", 32'(sw_clean), 32'h80);
                check("midrst_rise_e6",  32'(sw_rise),  32'h80);
            end
        end

        // Independent bits: bit0 then bit5 two edges later
        idle(1);
        sw_raw = 8'h00;
        idle(10);
        sw_raw = 8'h01;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 2) #1 sw_raw = 8'h21;
            if (k == 6) check("ind_rise_e6", 32'(sw_rise), 32'h01);
            if (k == 7) check("ind_rise_e7", 32'(sw_rise), 32'h00);
            if (k == 8) check("ind_rise_e8", 32'(sw_rise), 32'h20);
            if (k == 9) check("ind_rise_e9", 32'(sw_rise), 32'h00);
        end

        // Sticky flags: set, then clear coinciding with a new pulse
        idle(1);
        sw_raw = 8'h00;
        idle(10);
        clr_event = 1'b1;
        idle(1);
        clr_event = 1'b0;
        sw_raw = 8'h02;
        idle(8);
        check("sticky_set", 32'(sw_event), STICKY ? 32'h02 : 32'h0);
        sw_raw = 8'h06;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check("sticky_rise2", 32'(sw_rise), 32'h04);
                #1 clr_event = 1'b1;
            end
            if (k == 7) begin
                check("sticky_clr_set", 32'(sw_event), STICKY ? 32'h04 : 32'h0);
                #1 clr_event = 1'b0;
            end
        end

        // Random toggling, clears and occasional resets
        idle(1);
        rst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            flip = '0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0) flip[i] = 1'b1;
            sw_raw    = sw_raw ^ flip;
            clr_event = ($urandom_range(0, 31) == 0);
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                reset    = 1'b0;
                rst_left = $urandom_range(1, 3);
            end
        end
        reset     = 1'b1;
        clr_event = 1'b0;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
